// File: rtl/paddle_digitizer.sv
// RC-paddle digitizer: turns the two paddle comparator inputs into 8-bit positions
// once per video frame. Defining PADDLE_FILTER_EN adds a 2-tap rounding IIR smoother per axis.
module paddle_digitizer #(
   parameter logic [7:0] PADDLE_MIN = 8'd0,
   parameter logic [7:0] PADDLE_MAX = 8'd239
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hsync,
   input  logic       vsync,
   input  logic [8:0] vpos,
   input  logic       hpaddle,
   input  logic       vpaddle,
   output logic [7:0] paddle_x,
   output logic [7:0] paddle_y,
   output logic       paddle_valid,
   output logic       h_timeout,
   output logic       v_timeout
);

   localparam logic [1:0] WAIT_FRAME = 2'd0;
   localparam logic [1:0] MEASURE    = 2'd1;
   localparam logic [1:0] LATCH      = 2'd2;

   logic       hp_s1, hp_s2, vp_s1, vp_s2;
   logic       hs_q, vs_q;
   logic       hs_rise, vs_rise;
   logic       hs_rise_p0, vs_rise_p0, hp_p0, vp_p0;
   logic [8:0] vpos_p0;
   logic [1:0] state;
   logic [7:0] cap_x, cap_y;
   logic       seen_x, seen_y;
   logic [7:0] clamp_x, clamp_y;
`ifdef PADDLE_FILTER_EN
   logic       primed;
`endif

   // Range checks use the borrow bit of a 9-bit difference so a zero bound stays lint-clean.
   function automatic logic [7:0] clamp(input logic [7:0] v);
      logic [8:0] below, above;
      below = {1'b0, v} - {1'b0, PADDLE_MIN};
      above = {1'b0, PADDLE_MAX} - {1'b0, v};
      if (below[8])
         return PADDLE_MIN;
      else if (above[8])
         return PADDLE_MAX;
      return v;
   endfunction

`ifdef PADDLE_FILTER_EN
   function automatic logic [7:0] smooth(input logic [7:0] old_v, input logic [7:0] new_v);
      logic [8:0] sum;
      sum = {1'b0, old_v} + {1'b0, new_v} + 9'd1;
      return sum[8:1];
   endfunction
`endif

   assign hs_rise = hsync & ~hs_q;
   assign vs_rise = vsync & ~vs_q;
   assign clamp_x = clamp(seen_x ? cap_x : PADDLE_MAX);
   assign clamp_y = clamp(seen_y ? cap_y : PADDLE_MAX);

   // Stage p0: synchronised paddles and sync edges registered together with vpos.
   always_ff @(posedge clk) begin
      if (reset) begin
         hp_s1      <= 1'b0;
         hp_s2      <= 1'b0;
         vp_s1      <= 1'b0;
         vp_s2      <= 1'b0;
         hs_q       <= 1'b0;
         vs_q       <= 1'b0;
         hs_rise_p0 <= 1'b0;
         vs_rise_p0 <= 1'b0;
         hp_p0      <= 1'b0;
         vp_p0      <= 1'b0;
         vpos_p0    <= 9'd0;
      end else begin
         hp_s1      <= hpaddle;
         hp_s2      <= hp_s1;
         vp_s1      <= vpaddle;
         vp_s2      <= vp_s1;
         hs_q       <= hsync;
         vs_q       <= vsync;
         hs_rise_p0 <= hs_rise;
         vs_rise_p0 <= vs_rise;
         hp_p0      <= hp_s2;
         vp_p0      <= vp_s2;
         vpos_p0    <= vpos;
      end
   end

   // Stage p1: measurement FSM and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= WAIT_FRAME;
         cap_x        <= 8'd0;
         cap_y        <= 8'd0;
         seen_x       <= 1'b0;
         seen_y       <= 1'b0;
         paddle_x     <= PADDLE_MIN;
         paddle_y     <= PADDLE_MIN;
         paddle_valid <= 1'b0;
         h_timeout    <= 1'b0;
         v_timeout    <= 1'b0;
`ifdef PADDLE_FILTER_EN
         primed       <= 1'b0;
`endif
      end else begin
         paddle_valid <= 1'b0;
         case (state)
            WAIT_FRAME: begin
               if (vs_rise_p0) begin
                  state  <= MEASURE;
                  cap_x  <= 8'd0;
                  cap_y  <= 8'd0;
                  seen_x <= 1'b0;
                  seen_y <= 1'b0;
               end
            end
            MEASURE: begin
               // A line start coinciding with the frame edge is dropped rather than credited.
               if (vs_rise_p0) begin
                  state <= LATCH;
               end else if (hs_rise_p0 && !vpos_p0[8]) begin
                  if (!hp_p0) begin
                     cap_x  <= vpos_p0[7:0];
                     seen_x <= 1'b1;
                  end
                  if (!vp_p0) begin
                     cap_y  <= vpos_p0[7:0];
                     seen_y <= 1'b1;
                  end
               end
            end
            LATCH: begin
`ifdef PADDLE_FILTER_EN
               paddle_x <= primed ? smooth(paddle_x, clamp_x) : clamp_x;
               paddle_y <= primed ? smooth(paddle_y, clamp_y) : clamp_y;
               primed   <= 1'b1;
`else
               paddle_x <= clamp_x;
               paddle_y <= clamp_y;
`endif
               h_timeout    <= ~seen_x;
               v_timeout    <= ~seen_y;
               paddle_valid <= 1'b1;
               cap_x        <= 8'd0;
               cap_y        <= 8'd0;
               seen_x       <= 1'b0;
               seen_y       <= 1'b0;
               state        <= MEASURE;
            end
            default: state <= WAIT_FRAME;
         endcase
      end
   end

endmodule

// File: tb/tb_paddle_digitizer.sv
// Directed bench for paddle_digitizer: default-bound instance plus a PADDLE_MIN=16 instance.
module tb_paddle_digitizer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       hsync = 1'b0;
   logic       vsync = 1'b0;
   logic [8:0] vpos = 9'd0;
   logic       hpaddle = 1'b1;
   logic       vpaddle = 1'b1;
   logic [7:0] paddle_x, paddle_y, bx, by;
   logic       paddle_valid, h_timeout, v_timeout, b_valid, b_hto, b_vto;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   paddle_digitizer dut (
      .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .vpos(vpos),
      .hpaddle(hpaddle), .vpaddle(vpaddle), .paddle_x(paddle_x), .paddle_y(paddle_y),
      .paddle_valid(paddle_valid), .h_timeout(h_timeout), .v_timeout(v_timeout)
   );

   paddle_digitizer #(.PADDLE_MIN(8'd16), .PADDLE_MAX(8'd239)) dut_min16 (
      .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .vpos(vpos),
      .hpaddle(hpaddle), .vpaddle(vpaddle), .paddle_x(bx), .paddle_y(by),
      .paddle_valid(b_valid), .h_timeout(b_hto), .v_timeout(b_vto)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One scanline per loop pass; paddles are low inside [lo,hi] and, if vbl_low, on lines >= 256.
   task automatic frame(input int h_lo, input int h_hi, input int v_lo, input int v_hi,
                        input bit vbl_low, input int first, input int last);
      for (int l = first; l <= last; l++) begin
         vpos    = 9'(l);
         hpaddle = !((l >= h_lo && l <= h_hi) || (vbl_low && l >= 256));
         vpaddle = !((l >= v_lo && l <= v_hi) || (vbl_low && l >= 256));
         tick(3);
         hsync = 1'b1;
         tick(2);
         hsync = 1'b0;
         tick(1);
      end
   endtask

   // Raises vsync (optionally with a simultaneous hsync on a low-paddle line 10) and checks valid timing.
   task automatic vsync_edge(input string tag, input bit exp_pulse, input bit simul);
      if (simul) begin
         vpos    = 9'd10;
         hpaddle = 1'b0;
         vpaddle = 1'b0;
         tick(3);
         hsync = 1'b1;
      end
      vsync = 1'b1;
      tick(1);
      check({tag, "_valid_e0"}, paddle_valid, 0);
      tick(1);
      check({tag, "_valid_e1"}, paddle_valid, 0);
      tick(1);
      check({tag, "_valid_e2"}, paddle_valid, exp_pulse);
      tick(1);
      check({tag, "_valid_e3"}, paddle_valid, 0);
      hsync   = 1'b0;
      hpaddle = 1'b1;
      vpaddle = 1'b1;
      tick(2);
      vsync = 1'b0;
      tick(2);
   endtask

   initial begin
      tick(4);
      check("rst_x", paddle_x, 0);
      check("rst_y", paddle_y, 0);
      check("rst_valid", paddle_valid, 0);
      check("rst_hto", h_timeout, 0);
      check("rst_vto", v_timeout, 0);
      check("rst_b_x", bx, 16);
      check("rst_b_y", by, 16);
      reset = 1'b0;
      tick(2);

`ifndef PADDLE_FILTER_EN
      vsync_edge("arm", 1'b0, 1'b0);
      frame(0, 99, 0, 19, 1'b0, 0, 261);
      vsync_edge("f1", 1'b1, 1'b0);
      check("f1_x", paddle_x, 99);
      check("f1_y", paddle_y, 19);
      check("f1_hto", h_timeout, 0);
      check("f1_vto", v_timeout, 0);
      check("f1_b_valid_held", b_valid, 0);

      frame(1, 0, 0, 19, 1'b1, 0, 261);
      vsync_edge("f2", 1'b1, 1'b0);
      check("f2_x_timeout", paddle_x, 239);
      check("f2_hto", h_timeout, 1);
      check("f2_y", paddle_y, 19);
      check("f2_vto", v_timeout, 0);

      frame(0, 50, 5, 5, 1'b0, 0, 261);
      vsync_edge("f3", 1'b1, 1'b0);
      check("f3_x", paddle_x, 50);
      check("f3_hto", h_timeout, 0);
      check("f3_y", paddle_y, 5);
      check("f3_b_x", bx, 50);
      check("f3_b_y_min", by, 16);

      frame(0, 250, 0, 19, 1'b0, 0, 261);
      vsync_edge("f4", 1'b1, 1'b0);
      check("f4_x_clamp", paddle_x, 239);
      check("f4_hto", h_timeout, 0);
      check("f4_b_x_clamp", bx, 239);

      frame(0, 30, 0, 19, 1'b0, 0, 261);
      vsync_edge("f5", 1'b1, 1'b1);
      check("f5_x_unaffected", paddle_x, 30);
      check("f5_hto", h_timeout, 0);

      frame(1, 0, 0, 19, 1'b0, 0, 261);
      vsync_edge("f6", 1'b1, 1'b0);
      check("f6_simul_dropped_x", paddle_x, 239);
      check("f6_simul_dropped_hto", h_timeout, 1);

      frame(0, 99, 0, 19, 1'b0, 0, 59);
      reset = 1'b1;
      tick(3);
      check("midrst_x", paddle_x, 0);
      check("midrst_y", paddle_y, 0);
      check("midrst_hto", h_timeout, 0);
      check("midrst_valid", paddle_valid, 0);
      reset = 1'b0;
      frame(0, 99, 0, 19, 1'b0, 60, 261);
      vsync_edge("rearm", 1'b0, 1'b0);
      check("rearm_x", paddle_x, 0);
      frame(0, 70, 0, 40, 1'b0, 0, 261);
      vsync_edge("f8", 1'b1, 1'b0);
      check("f8_x", paddle_x, 70);
      check("f8_y", paddle_y, 40);
`endif

      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(2);
      vsync_edge("flt_arm", 1'b0, 1'b0);
      frame(0, 100, 0, 19, 1'b0, 0, 261);
      vsync_edge("flt1", 1'b1, 1'b0);
      check("flt1_x", paddle_x, 100);
      check("flt1_y", paddle_y, 19);
      frame(0, 201, 0, 19, 1'b0, 0, 261);
      vsync_edge("flt2", 1'b1, 1'b0);
`ifdef PADDLE_FILTER_EN
      check("flt2_x", paddle_x, 151);
`else
      check("flt2_x", paddle_x, 201);
`endif
      check("flt2_y", paddle_y, 19);
      frame(0, 151, 0, 19, 1'b0, 0, 261);
      vsync_edge("flt3", 1'b1, 1'b0);
      check("flt3_x", paddle_x, 151);
      check("flt3_hto", h_timeout, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/paddle_digitizer.md
Name: paddle_digitizer

Overview:
- Upstream stage of the racing game top. Converts the two raw RC-paddle comparator inputs into stable 8-bit positions once per video frame. Those positions are consumed as paddle_x (steering) and paddle_y (throttle).
- Timing is taken from the hsync/vsync/vpos outputs of the video sync generator.
- Replaces ad-hoc sampling on an hsync clock with a fully clk-synchronous measurement FSM, with clamping, timeout flags and a per-frame valid strobe.

Parameters:
- PADDLE_MIN, 8'd0, lower clamp for both outputs; also the reset value of the outputs.
- PADDLE_MAX, 8'd239, upper clamp for both outputs; also the value used on timeout.

Ports:
- clk  input  1  system clock (pixel clock)
- reset  input  1  synchronous, active-high reset
- hsync  input  1  horizontal sync level from sync generator
- vsync  input  1  vertical sync level from sync generator
- vpos  input  9  current scanline from sync generator
- hpaddle  input  1  raw horizontal paddle comparator; asynchronous; low = not yet tripped
- vpaddle  input  1  raw vertical paddle comparator; asynchronous; low = not yet tripped
- paddle_x  output  8  clamped horizontal position, held for a whole frame
- paddle_y  output  8  clamped vertical position, held for a whole frame
- paddle_valid  output  1  one-cycle pulse when paddle_x/paddle_y update
- h_timeout  output  1  last frame had no low hpaddle sample; held until next update
- v_timeout  output  1  last frame had no low vpaddle sample; held until next update

Behaviour:
- Synchronisers: hpaddle and vpaddle each pass through a 2-flop synchroniser. hsync and vsync are registered once (hs_q, vs_q).
- Edge detection: hs_rise = hsync & ~hs_q; vs_rise = vsync & ~vs_q.
- FSM states are WAIT_FRAME, MEASURE, LATCH.
  - WAIT_FRAME (entered on reset): ignore hsync. On vs_rise, go to MEASURE with the capture state cleared. No output update.
  - MEASURE: on hs_rise with vpos[8]==0, if the synchronised paddle is low, set cap <= vpos[7:0] and seen <= 1. This is done per axis, and the last low line wins. Lines with vpos[8]==1 are ignored. On vs_rise, go to LATCH.
  - LATCH (exactly 1 cycle):
    - per axis, raw = seen ? cap : PADDLE_MAX; timeout = ~seen;
    - clamp raw to [PADDLE_MIN, PADDLE_MAX];
    - register outputs and pulse paddle_valid;
    - clear cap/seen; return to MEASURE. The frame just started is measured.
- Latency: vsync is first high at clock edge E0 (vs_q still low). The LATCH state is entered at E0+1. paddle_x, paddle_y, h_timeout and v_timeout update at E0+2, and paddle_valid is high for the cycle after E0+2. This is a fixed 2 cycles with no stall.
- Simultaneous hs_rise and vs_rise in MEASURE: vs_rise wins. That hsync sample is discarded and is not credited to either frame.
- hs_rise during LATCH: discarded.
- The first vsync after reset only arms measurement. The first paddle_valid follows the second vsync edge.
- Reset, including mid-frame: FSM goes to WAIT_FRAME.
  - cap and seen are cleared.
  - paddle_x and paddle_y become PADDLE_MIN.
  - paddle_valid, h_timeout and v_timeout become 0.
  - Synchroniser and edge registers are cleared.
- Width rules: clamp comparisons are unsigned 8-bit. vpos bit 8 is used only as the ignore qualifier.

Optional Feature:
- Macro: PADDLE_FILTER_EN.
- When defined, each axis output is a 2-tap IIR smoother: new_out = (old_out + clamped_raw + 1) >> 1.
  - The sum is computed in 9 bits with round-half-up.
  - The result is always within [PADDLE_MIN, PADDLE_MAX].
  - The first LATCH after reset loads clamped_raw directly (no averaging with the reset value), tracked by a per-design "primed" flag that reset clears.
  - A timeout frame still filters toward PADDLE_MAX.
- When undefined, outputs equal clamped_raw directly; the filter and primed flag do not exist.
- Latency and valid timing are identical in both builds.

Test Plan:
- Reset, then two frames; hpaddle low on lines 0..99 then high, vpaddle low on lines 0..19 then high -> after the second vsync edge: paddle_x=99, paddle_y=19, paddle_valid pulse at exactly E0+2, timeouts 0; no pulse after the first vsync edge.
- hpaddle held high all frame -> paddle_x=239 (PADDLE_MAX), h_timeout=1. Next frame with low through line 50 -> paddle_x=50, h_timeout=0.
- PADDLE_MIN=16 and vpaddle low only on line 5 -> paddle_y=16. hpaddle low through line 250 (< 256) -> paddle_x=239 clamped.
- hs_rise in the same cycle as vs_rise, with hpaddle low only on that line -> the sample is ignored: h_timeout=1 for the new frame, and the previous frame's result is unaffected.
- Reset asserted mid-frame after 60 low lines -> outputs return to PADDLE_MIN, no paddle_valid at the next vsync edge, valid result only after the following vsync edge.
- PADDLE_FILTER_EN build: first frame raw=100 -> 100; next frame raw=201 -> 151; next frame raw=151 -> 151.
